regfile_sb: RTL and testbench

//  Parametrised multi-read-port integer register file with an integrated busy scoreboard.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_scoreboard.sv | 77 +++++++
 rtl/regfile_sb.sv | 119 +++++++++++
 tb/tb_regfile_sb.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared constants and types for the integer register file with a busy
//   scoreboard (regfile_sb and regfile_scoreboard).
//
//   Contents:
//     XLEN_DEF   default data width in bits
//     NREGS_DEF  default number of architectural registers
//     reg_addr_t register index for the default 32-entry configuration
//     xword_t    data word for the default 32-bit configuration
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] xword_t;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//   Per-register pending-write tracker. A register becomes busy when an
//   instruction targeting it issues and goes idle when its writeback lands.
//   Register 0 is never busy. A writeback to a register that is neither busy
//   nor being issued in the same cycle raises a sticky wb_unexpected flag.
//
//   Ports:
//     clk            in   system clock, rising edge
//     rst_n          in   asynchronous active-low reset
//     issue_valid    in   mark issue_rd pending this cycle
//     issue_rd       in   destination register of the issued instruction
//     we             in   writeback enable
//     waddr          in   writeback register
//     busy_vec       out  pending bit per register (bit 0 always 0)
//     wb_unexpected  out  sticky: writeback hit a non-pending register
// -----------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_rd,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  output logic [NREGS-1:0] busy_vec,
  output logic             wb_unexpected
);

  // Register 0 can never hold a pending bit.
  localparam logic [NREGS-1:0] LIVE_MASK = {{(NREGS-1){1'b1}}, 1'b0};

  logic [NREGS-1:0] busy_q, busy_d;
  logic             unexp_q, unexp_d;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] clr_vec;
  logic             wr_live;

  assign wr_live = we && (waddr != '0);

  // One-hot decode of issue and writeback targets.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid) begin
      set_vec[issue_rd] = 1'b1;
    end
    if (we) begin
      clr_vec[waddr] = 1'b1;
    end
  end

  // Set has priority over clear: when a younger instruction issues to the
  // same register an older one is writing back, the younger one now owns it.
  always_comb begin
    busy_d  = (set_vec | (busy_q & ~clr_vec)) & LIVE_MASK;
    unexp_d = unexp_q | (wr_live && !busy_q[waddr] && !set_vec[waddr]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      unexp_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      unexp_q <= unexp_d;
    end
  end

  assign busy_vec      = busy_q;
  assign wb_unexpected = unexp_q;

endmodule : regfile_scoreboard

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
//   Multi-read-port integer register file with an integrated busy scoreboard.
//   Register 0 reads as zero, ignores writes and is never busy. Reads are
//   combinational; writes land on the rising clock edge. The scoreboard
//   (regfile_scoreboard) tracks which registers have a pending writeback so
//   control can stall on RAW hazards.
//
//   Build option:
//     REGFILE_BYPASS_EN  when defined, a read port addressing the register
//                        being written this cycle sees wdata immediately and
//                        reports not-busy (unless the same register is also
//                        issued this cycle). When undefined, reads return the
//                        pre-write contents and rbusy is the registered
//                        busy_vec bit.
//
//   Ports:
//     clk            in   system clock, rising edge
//     rst_n          in   asynchronous active-low reset (clears all state)
//     raddr          in   read addresses, port i at [i*AW +: AW]
//     rdata          out  read data, port i at [i*XLEN +: XLEN]
//     rbusy          out  port i addresses a register with a pending write
//     issue_valid    in   mark issue_rd pending this cycle
//     issue_rd       in   destination register of the issued instruction
//     we             in   writeback enable
//     waddr          in   writeback register
//     wdata          in   writeback data
//     busy_vec       out  pending bit per register (bit 0 always 0)
//     wb_unexpected  out  sticky: writeback hit a non-pending register
// -----------------------------------------------------------------------------
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NREAD = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREAD*AW-1:0]   raddr,
  output logic [NREAD*XLEN-1:0] rdata,
  output logic [NREAD-1:0]      rbusy,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_rd,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [XLEN-1:0]       wdata,
  output logic [NREGS-1:0]      busy_vec,
  output logic                  wb_unexpected
);

  logic [XLEN-1:0] rf_q [NREGS];
  logic            wr_live;

  assign wr_live = we && (waddr != '0);

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  regfile_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .we            (we),
    .waddr         (waddr),
    .busy_vec      (busy_vec),
    .wb_unexpected (wb_unexpected)
  );

  // ---------------------------------------------------------------------------
  // Data array. Entry 0 is never written, so it stays at its reset value of 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        rf_q[r] <= '0;
      end
    end else if (wr_live) begin
      rf_q[waddr] <= wdata;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // A same-cycle issue to the register being written re-arms it, so the
  // forwarded value is already stale from the consumer's point of view.
  logic issue_hits_wr;
  assign issue_hits_wr = issue_valid && (issue_rd == waddr);
`endif

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    logic            rb;

    assign ra = raddr[g*AW +: AW];

    always_comb begin
      rd = (ra == '0) ? '0 : rf_q[ra];
      rb = busy_vec[ra];
`ifdef REGFILE_BYPASS_EN
      if (wr_live && (ra == waddr)) begin
        rd = wdata;
        rb = issue_hits_wr;
      end
`endif
    end

    assign rdata[g*XLEN +: XLEN] = rd;
    assign rbusy[g]              = rb;
  end

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  // Default-configuration DUT signals
  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] busy_vec;
  logic        wb_unexpected;

  // Wide configuration DUT (NREAD=4, XLEN=64) shares control inputs
  logic [19:0]  raddr64;
  logic [255:0] rdata64;
  logic [3:0]   rbusy64;
  logic [63:0]  wdata64;
  logic [31:0]  busy_vec64;
  logic         wb_unexpected64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .raddr         (raddr),
    .rdata         (rdata),
    .rbusy         (rbusy),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .we            (we),
    .waddr         (waddr),
    .wdata         (wdata),
    .busy_vec      (busy_vec),
    .wb_unexpected (wb_unexpected)
  );

  regfile_sb #(.XLEN(64), .NREAD(4)) dut64 (
    .clk           (clk),
    .rst_n         (rst_n),
    .raddr         (raddr64),
    .rdata         (rdata64),
    .rbusy         (rbusy64),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .we            (we),
    .waddr         (waddr),
    .wdata         (wdata64),
    .busy_vec      (busy_vec64),
    .wb_unexpected (wb_unexpected64)
  );

  // Reference model state
  logic [31:0] m_rf   [32];
  logic [63:0] m_rf64 [32];
  logic [31:0] m_busy;
  logic        m_unexp;

  // Scoreboard of pending expectations
  // kind: 0 rdata (32-bit dut), 1 rbusy (32-bit dut), 2 busy_vec,
  //       3 wb_unexpected, 4 rdata (64-bit dut)
  typedef struct {
    string       tag;
    int          kind;
    int          port;
    logic [4:0]  addr;
    logic [63:0] exp;
  } exp_t;

  exp_t q[$];

  task automatic push(input string tag, input int kind, input int port,
                      input logic [4:0] addr, input logic [63:0] exp);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.port = port;
    e.addr = addr;
    e.exp  = exp;
    q.push_back(e);
  endtask

  function automatic logic [63:0] m_read(input logic [4:0] a);
    return (a == 5'd0) ? 64'd0 : {32'd0, m_rf[a]};
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_rf[r]   = '0;
      m_rf64[r] = '0;
    end
    m_busy  = '0;
    m_unexp = 1'b0;
  endtask

  task automatic drain();
    exp_t        e;
    logic [63:0] obs;
    while (q.size() > 0) begin
      e   = q.pop_front();
      obs = 'x;
      case (e.kind)
        0: begin
          raddr[e.port*5 +: 5] = e.addr;
          #1;
          obs = {32'd0, rdata[e.port*32 +: 32]};
        end
        1: begin
          raddr[e.port*5 +: 5] = e.addr;
          #1;
          obs = {63'd0, rbusy[e.port]};
        end
        2: obs = {32'd0, busy_vec};
        3: obs = {63'd0, wb_unexpected};
        default: begin
          raddr64[e.port*5 +: 5] = e.addr;
          #1;
          obs = rdata64[e.port*64 +: 64];
        end
      endcase
      checks++;
      assert (obs === e.exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic op(input logic iv, input logic [4:0] ird, input logic w,
                    input logic [4:0] wa, input logic [31:0] wd);
    issue_valid = iv;
    issue_rd    = ird;
    we          = w;
    waddr       = wa;
    wdata       = wd;
    wdata64     = {~wd, wd};
  endtask

  // Advance the model with the currently driven inputs, then clock the DUT.
  task automatic step();
    if (we && waddr != 5'd0) begin
      if (!m_busy[waddr] && !(issue_valid && issue_rd == waddr)) m_unexp = 1'b1;
      m_rf[waddr]   = wdata;
      m_rf64[waddr] = wdata64;
      m_busy[waddr] = 1'b0;
    end
    if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
    @(posedge clk);
    #1;
    op(1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n   = 1'b0;
    raddr   = '0;
    raddr64 = '0;
    op(1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    model_reset();

    // Reset state
    #12;
    push("rst_busy_vec", 2, 0, 5'd0, 64'd0);
    push("rst_unexp",    3, 0, 5'd0, 64'd0);
    push("rst_rd_x5",    0, 0, 5'd5, 64'd0);
    drain();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1. Reset mid-run clears array, busy bits and sticky flag immediately
    op(1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    step();
    op(1'b1, 5'd7, 1'b0, 5'd0, 32'd0);
    step();
    push("t1_rd_x5",   0, 0, 5'd5, m_read(5'd5));
    push("t1_busy",    2, 0, 5'd0, {32'd0, m_busy});
    push("t1_unexp",   3, 0, 5'd0, {63'd0, m_unexp});
    drain();
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    push("t1_async_rd_x5", 0, 0, 5'd5, 64'd0);
    push("t1_async_busy",  2, 0, 5'd0, 64'd0);
    push("t1_async_unexp", 3, 0, 5'd0, 64'd0);
    push("t1_async_rbusy_x7", 1, 1, 5'd7, 64'd0);
    drain();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // In-flight issue/write discarded by a reset spanning the edge
    op(1'b1, 5'd8, 1'b1, 5'd6, 32'h66);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    op(1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    push("t1_discard_rd_x6", 0, 0, 5'd6, 64'd0);
    push("t1_discard_busy",  2, 0, 5'd0, 64'd0);
    push("t1_discard_unexp", 3, 0, 5'd0, 64'd0);
    drain();

    // 2. Register 0 guard
    op(1'b1, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
    step();
    push("t2_rd_x0",    0, 0, 5'd0, 64'd0);
    push("t2_rbusy_x0", 1, 1, 5'd0, 64'd0);
    push("t2_busy",     2, 0, 5'd0, 64'd0);
    push("t2_unexp",    3, 0, 5'd0, 64'd0);
    drain();

    // 3. Issue then writeback four cycles later
    op(1'b1, 5'd3, 1'b0, 5'd0, 32'd0);
    step();
    push("t3_rbusy_c1", 1, 0, 5'd3, 64'd1);
    drain();
    step();
    step();
    step();
    push("t3_rbusy_c4", 1, 0, 5'd3, 64'd1);
    push("t3_busy_c4",  2, 0, 5'd0, {32'd0, m_busy});
    drain();
    op(1'b0, 5'd0, 1'b1, 5'd3, 32'h12);
    step();
    push("t3_rbusy_c5", 1, 0, 5'd3, 64'd0);
    push("t3_rd_c5",    0, 1, 5'd3, 64'h12);
    push("t3_unexp",    3, 0, 5'd0, 64'd0);
    drain();

    // 4. Same-cycle issue and writeback: set wins, data still written
    op(1'b1, 5'd9, 1'b0, 5'd0, 32'd0);
    step();
    op(1'b1, 5'd9, 1'b1, 5'd9, 32'h55);
    step();
    push("t4_rbusy_x9", 1, 0, 5'd9, 64'd1);
    push("t4_rd_x9",    0, 1, 5'd9, 64'h55);
    push("t4_unexp",    3, 0, 5'd0, 64'd0);
    push("t4_busy",     2, 0, 5'd0, {32'd0, m_busy});
    drain();

    // 5. Writeback to an idle register raises the sticky flag
    op(1'b0, 5'd0, 1'b1, 5'd10, 32'h1);
    step();
    push("t5_rd_x10", 0, 0, 5'd10, 64'h1);
    push("t5_unexp",  3, 0, 5'd0, 64'd1);
    drain();
    step();
    step();
    push("t5_unexp_sticky", 3, 0, 5'd0, {63'd0, m_unexp});
    drain();

    // 6. Same-cycle read of the register being written
    op(1'b0, 5'd0, 1'b1, 5'd4, 32'h11);
    step();
    op(1'b0, 5'd0, 1'b1, 5'd4, 32'hA5);
    #1;
`ifdef REGFILE_BYPASS_EN
    push("t6_byp_rd",    0, 0, 5'd4, 64'hA5);
    push("t6_byp_rd64",  4, 3, 5'd4, {~32'hA5, 32'hA5});
`else
    push("t6_byp_rd",    0, 0, 5'd4, m_read(5'd4));
    push("t6_byp_rd64",  4, 3, 5'd4, m_rf64[4]);
`endif
    push("t6_byp_rbusy", 1, 0, 5'd4, 64'd0);
    drain();
    step();
    push("t6_post_rd",   0, 0, 5'd4, 64'hA5);
    push("t6_post_rd64", 4, 3, 5'd4, {~32'hA5, 32'hA5});
    drain();

    op(1'b1, 5'd4, 1'b1, 5'd4, 32'h77);
    #1;
`ifdef REGFILE_BYPASS_EN
    push("t6_iss_rbusy", 1, 1, 5'd4, 64'd1);
    push("t6_iss_rd",    0, 1, 5'd4, 64'h77);
`else
    push("t6_iss_rbusy", 1, 1, 5'd4, {63'd0, m_busy[4]});
    push("t6_iss_rd",    0, 1, 5'd4, m_read(5'd4));
`endif
    drain();
    step();
    push("t6_iss_post_rbusy", 1, 0, 5'd4, 64'd1);
    push("t6_iss_post_rd64",  4, 2, 5'd4, m_rf64[4]);
    push("t6_final_busy",     2, 0, 5'd0, {32'd0, m_busy});
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_regfile_sb
